// File: rtl/txrx_ack_scheduler.sv
// Transmit-strobe / acknowledge-window scheduler: one strobe per request, then count
// receiver-high samples over a fixed window and grade the count. Optional macro: TXRX_EARLY_FAIL_EN.
module txrx_ack_scheduler #(
  parameter int MIN_ACK = 2,
  parameter int MAX_ACK = 5,
  parameter int WINDOW  = 16,
  parameter int CNT_W   = $clog2(MAX_ACK + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             transmiter,
  input  logic             recevier,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] ack_count
);

  localparam int WIN_W = $clog2(WINDOW + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO_C = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MIN_C  = CNT_W'(MIN_ACK);
  localparam logic [CNT_W-1:0] CNT_MAX_C  = CNT_W'(MAX_ACK);
  localparam logic [CNT_W-1:0] CNT_SAT_C  = CNT_W'(MAX_ACK + 1);

  localparam logic [WIN_W-1:0] WIN_ZERO_C = WIN_W'(0);
  localparam logic [WIN_W-1:0] WIN_ONE_C  = WIN_W'(1);
  localparam logic [WIN_W-1:0] WIN_LAST_C = WIN_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TX      = 2'd1,
    S_COLLECT = 2'd2,
    S_REPORT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIN_W-1:0] win_q, win_d;

  logic             hit_s;
  logic             last_s;
  logic             early_s;

  function automatic logic in_range(input logic [CNT_W-1:0] cnt);
    in_range = (cnt >= CNT_MIN_C) && (cnt <= CNT_MAX_C);
  endfunction

  // Sample qualification: saturating hit, last window sample, optional early termination.
  always_comb begin
    hit_s   = 1'b0;
    last_s  = 1'b0;
    early_s = 1'b0;
    if (state_q == S_COLLECT) begin
      hit_s  = recevier && (cnt_q != CNT_SAT_C);
      last_s = (win_q == WIN_LAST_C);
`ifdef TXRX_EARLY_FAIL_EN
      early_s = hit_s && (cnt_q == (CNT_SAT_C - CNT_ONE_C));
`else
      early_s = 1'b0;
`endif
    end else begin
      hit_s   = 1'b0;
      last_s  = 1'b0;
      early_s = 1'b0;
    end
  end

  // Next-state and registered-output logic; strobe and result flags default low.
  always_comb begin
    state_d = state_q;
    tx_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    cnt_d   = cnt_q;
    win_d   = win_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_TX;
          tx_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = CNT_ZERO_C;
          win_d   = WIN_ZERO_C;
        end else begin
          busy_d  = 1'b0;
        end
      end

      // The receiver is deliberately not looked at during the strobe cycle.
      S_TX: begin
        state_d = S_COLLECT;
        busy_d  = 1'b1;
      end

      S_COLLECT: begin
        busy_d = 1'b1;
        win_d  = win_q + WIN_ONE_C;
        if (hit_s) begin
          cnt_d = cnt_q + CNT_ONE_C;
        end else begin
          cnt_d = cnt_q;
        end
        if (last_s || early_s) begin
          state_d = S_REPORT;
          done_d  = 1'b1;
          pass_d  = in_range(cnt_d);
          fail_d  = ~in_range(cnt_d);
        end else begin
          state_d = S_COLLECT;
        end
      end

      S_REPORT: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = CNT_ZERO_C;
        win_d   = WIN_ZERO_C;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      cnt_q   <= CNT_ZERO_C;
      win_q   <= WIN_ZERO_C;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
    end
  end

  assign transmiter = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign ack_count  = cnt_q;

endmodule

// File: tb/tb_txrx_ack_scheduler.sv
// Directed bench for txrx_ack_scheduler with MIN_ACK=2, MAX_ACK=5, WINDOW=8.
// Expected counts and verdicts are hand-computed per vector.
module tb_txrx_ack_scheduler;

  localparam int MIN_ACK = 2;
  localparam int MAX_ACK = 5;
  localparam int WINDOW  = 8;
  localparam int CNT_W   = $clog2(MAX_ACK + 2);
`ifdef TXRX_EARLY_FAIL_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             req;
  logic             transmiter;
  logic             recevier;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [CNT_W-1:0] ack_count;

  int n_cmp;
  int n_bad;

  txrx_ack_scheduler #(
    .MIN_ACK(MIN_ACK),
    .MAX_ACK(MAX_ACK),
    .WINDOW (WINDOW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .transmiter(transmiter),
    .recevier  (recevier),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .ack_count (ack_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; pat[k] drives COLLECT sample k+1.
  task automatic run_txn(input string tag, input logic [7:0] pat,
                         input int exp_cnt, input logic exp_pass);
    int  run_cnt;
    bit  last;
    run_cnt = 0;
    req = 1'b1;
    tick();
    check({tag, ".tx"}, transmiter, 1);
    check({tag, ".busy_tx"}, busy, 1);
    check({tag, ".cnt_clr"}, ack_count, 0);
    req = 1'b0;
    tick();
    check({tag, ".tx_off"}, transmiter, 0);
    for (int k = 0; k < WINDOW; k++) begin
      recevier = pat[k];
      tick();
      recevier = 1'b0;
      if (pat[k] && run_cnt < MAX_ACK + 1) run_cnt++;
      last = (k == WINDOW - 1) || (EARLY && pat[k] && run_cnt == MAX_ACK + 1);
      check({tag, ".done_t"}, done, last);
      if (last) begin
        check({tag, ".cnt"}, ack_count, exp_cnt);
        check({tag, ".pass"}, pass, exp_pass);
        check({tag, ".fail"}, fail, !exp_pass);
        break;
      end
    end
    tick();
    check({tag, ".done_off"}, done, 0);
    check({tag, ".busy_off"}, busy, 0);
    check({tag, ".pass_off"}, pass, 0);
    check({tag, ".fail_off"}, fail, 0);
    check({tag, ".cnt_hold"}, ack_count, exp_cnt);
  endtask

  initial begin
    bit seen;
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    req      = 1'b0;
    recevier = 1'b0;
    tick();
    tick();
    check("rst.tx", transmiter, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.pass", pass, 0);
    check("rst.fail", fail, 0);
    check("rst.cnt", ack_count, 0);
    rst = 1'b0;
    tick();

    run_txn("T1", 8'b0010_0101, 3, 1'b1);
    run_txn("T2a", 8'b0000_0001, 1, 1'b0);
    run_txn("T2b", 8'b0000_0000, 0, 1'b0);
    run_txn("T3a", 8'b0001_1110, 4, 1'b1);
    run_txn("T3b", 8'b1111_1111, 6, 1'b0);
    run_txn("T4", 8'b0011_1111, 6, 1'b0);
    run_txn("Bmax", 8'b1010_1011, 5, 1'b1);
    run_txn("Bmin", 8'b1000_0001, 2, 1'b1);

    // T5: receiver pulse on the strobe cycle only, req held throughout
    req = 1'b1;
    tick();
    check("T5.tx", transmiter, 1);
    recevier = 1'b1;
    tick();
    recevier = 1'b0;
    for (int k = 0; k < WINDOW; k++) tick();
    check("T5.done", done, 1);
    check("T5.cnt", ack_count, 0);
    check("T5.fail", fail, 1);
    tick();
    check("T5.gap_tx", transmiter, 0);
    tick();
    check("T5.next_tx", transmiter, 1);
    req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("T5.drain", seen, 1);
    tick();

    // T6: reset mid-COLLECT aborts, then a clean transaction
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    recevier = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("T6.tx", transmiter, 0);
    check("T6.busy", busy, 0);
    check("T6.done", done, 0);
    check("T6.pass", pass, 0);
    check("T6.fail", fail, 0);
    check("T6.cnt", ack_count, 0);
    recevier = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check("T6.no_done", seen, 0);
    run_txn("T6r", 8'b0010_0101, 3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
